// File: rtl/intan_emu_pkg.sv
// Shared types, opcodes and register ROM contents for the Intan RHD
// peripheral emulator (intan_peripheral_emulator and its edge synchroniser).
package intan_emu_pkg;

    typedef enum logic [2:0] {
        CMD_CONVERT,
        CMD_CALIBRATE,
        CMD_CLEAR,
        CMD_WRITE,
        CMD_READ,
        CMD_NONE
    } cmd_e;

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } state_e;

    // One response slot: one 32-bit word per CIPO line, each {dieA, dieB}
    typedef struct packed {
        logic [31:0] line0;
        logic [31:0] line1;
    } slot_t;

    localparam logic [15:0] OP_CALIBRATE = 16'h5500;
    localparam logic [15:0] OP_CLEAR     = 16'h6A00;

    localparam int NUM_REGS = 18;

    // Read-only company ID "INTAN" and die revision
    localparam logic [7:0] ROM_REG40 = 8'h49;
    localparam logic [7:0] ROM_REG41 = 8'h4E;
    localparam logic [7:0] ROM_REG42 = 8'h54;
    localparam logic [7:0] ROM_REG43 = 8'h41;
    localparam logic [7:0] ROM_REG44 = 8'h4E;
    localparam logic [7:0] ROM_REG60 = 8'h01;

    function automatic cmd_e decode_cmd(input logic [15:0] word);
        cmd_e cmd;
        case (word[15:14])
            2'b00:   cmd = CMD_CONVERT;
            2'b10:   cmd = CMD_WRITE;
            2'b11:   cmd = CMD_READ;
            default: begin
                if (word == OP_CALIBRATE) begin
                    cmd = CMD_CALIBRATE;
                end else if (word == OP_CLEAR) begin
                    cmd = CMD_CLEAR;
                end else begin
                    cmd = CMD_NONE;
                end
            end
        endcase
        return cmd;
    endfunction

    function automatic logic [7:0] rom_value(input logic [5:0] addr);
        logic [7:0] v;
        case (addr)
            6'd40:   v = ROM_REG40;
            6'd41:   v = ROM_REG41;
            6'd42:   v = ROM_REG42;
            6'd43:   v = ROM_REG43;
            6'd44:   v = ROM_REG44;
            6'd60:   v = ROM_REG60;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/intan_emu_edge_sync.sv
// Input synchroniser for csn/sclk/copi plus single-cycle edge pulses.
// All stages reset to 0 so csn looks "low" after reset: a frame already in
// progress cannot produce a csn fall until csn has been seen high again.
module intan_emu_edge_sync #(
    parameter int SYNC_STAGES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic csn_i,
    input  logic sclk_i,
    input  logic copi_i,
    output logic csnFall_o,
    output logic csnRise_o,
    output logic sclkRise_o,
    output logic sclkFall_o,
    output logic copi_o
);

    logic [2:0] stage_q [SYNC_STAGES];
    logic [1:0] prev_q;
    logic [2:0] synced;

    assign synced = stage_q[SYNC_STAGES-1];

    // Synchroniser chain for {csn, sclk, copi} and one extra stage for edge detect
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage_q[i] <= '0;
            end
            prev_q <= '0;
        end else begin
            stage_q[0] <= {csn_i, sclk_i, copi_i};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
            prev_q <= synced[2:1];
        end
    end

    assign csnFall_o  = ~synced[2] &  prev_q[1];
    assign csnRise_o  =  synced[2] & ~prev_q[1];
    assign sclkRise_o =  synced[1] & ~prev_q[0];
    assign sclkFall_o = ~synced[1] &  prev_q[0];
    assign copi_o     =  synced[0];

endmodule

// File: rtl/intan_peripheral_emulator.sv
// Dual-die Intan RHD headstage emulator: decodes 16-bit COPI commands, keeps
// the register file and shifts DDR responses on cipo0/cipo1 with a two-frame
// command-to-result latency.
// Optional: define INTAN_EMU_CABLE_DELAY_EN to add a cable_delay-selected
// 0..15 clk delay line on both CIPO outputs.
module intan_peripheral_emulator
    import intan_emu_pkg::*;
#(
    parameter int         SYNC_STAGES = 1,
    parameter logic [7:0] CHIP_ID     = 8'd3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        csn,
    input  logic        sclk,
    input  logic        copi,
    output logic        cipo0,
    output logic        cipo1,
    input  logic [3:0]  cable_delay,
    output logic [31:0] frame_count,
    output logic [15:0] frame_err_count,
    output logic [15:0] last_cmd
);

    logic csnFall, csnRise, sclkRise, sclkFall, copiSync;

    intan_emu_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .clk       (clk),
        .rst       (rst),
        .csn_i     (csn),
        .sclk_i    (sclk),
        .copi_i    (copi),
        .csnFall_o (csnFall),
        .csnRise_o (csnRise),
        .sclkRise_o(sclkRise),
        .sclkFall_o(sclkFall),
        .copi_o    (copiSync)
    );

    state_e      state_q, state_d;
    logic [31:0] tx0_q, tx0_d, tx1_q, tx1_d;
    logic [15:0] rx_q, rx_d;
    logic [4:0]  bitCnt_q, bitCnt_d;
    logic [31:0] frameCount_q, frameCount_d;
    logic [15:0] errCount_q, errCount_d;
    logic [15:0] lastCmd_q, lastCmd_d;
    slot_t       slotOld_q, slotOld_d, slotNew_q, slotNew_d;
    logic [7:0]  samp_q, samp_d;
    logic [7:0]  regs_q [NUM_REGS];
    logic [7:0]  regs_d [NUM_REGS];

    cmd_e        cmd;
    logic [5:0]  regAddr;
    logic [7:0]  regData, readVal;
    logic [15:0] dieWord;
    slot_t       result;

    // Turn the received command word into the four die responses
    always_comb begin
        cmd     = decode_cmd(rx_q);
        regAddr = rx_q[13:8];
        regData = rx_q[7:0];
        readVal = 8'h00;
        if (regAddr <= 6'd17) begin
            readVal = regs_q[regAddr[4:0]];
        end else if (regAddr == 6'd63) begin
            readVal = CHIP_ID;
        end else begin
            readVal = rom_value(regAddr);
        end
        case (cmd)
            CMD_WRITE: dieWord = {8'hFF, regData};
            CMD_READ:  dieWord = {8'h00, readVal};
            default:   dieWord = 16'h0000;
        endcase
        if (cmd == CMD_CONVERT) begin
            result.line0 = {2'd0, regAddr, samp_q, 2'd1, regAddr, samp_q};
            result.line1 = {2'd2, regAddr, samp_q, 2'd3, regAddr, samp_q};
        end else begin
            result.line0 = {dieWord, dieWord};
            result.line1 = {dieWord, dieWord};
        end
    end

    // Frame FSM: load responses on csn fall, shift on SCLK edges, commit on csn rise
    always_comb begin
        state_d      = state_q;
        tx0_d        = tx0_q;
        tx1_d        = tx1_q;
        rx_d         = rx_q;
        bitCnt_d     = bitCnt_q;
        frameCount_d = frameCount_q;
        errCount_d   = errCount_q;
        lastCmd_d    = lastCmd_q;
        slotOld_d    = slotOld_q;
        slotNew_d    = slotNew_q;
        samp_d       = samp_q;
        regs_d       = regs_q;
        case (state_q)
            ST_IDLE: begin
                if (csnFall) begin
                    state_d  = ST_SHIFT;
                    tx0_d    = slotOld_q.line0;
                    tx1_d    = slotOld_q.line1;
                    rx_d     = '0;
                    bitCnt_d = '0;
                end
            end
            ST_SHIFT: begin
                if (csnRise) begin
                    state_d = ST_IDLE;
                    tx0_d   = '0;
                    tx1_d   = '0;
                    if (bitCnt_q == 5'd16) begin
                        frameCount_d = frameCount_q + 32'd1;
                        lastCmd_d    = rx_q;
                        slotOld_d    = slotNew_q;
                        slotNew_d    = result;
                        case (cmd)
                            CMD_CONVERT: samp_d = samp_q + 8'd1;
                            CMD_CLEAR:   samp_d = 8'h00;
                            CMD_WRITE: begin
                                if (regAddr <= 6'd17) begin
                                    regs_d[regAddr[4:0]] = regData;
                                end
                            end
                            default: ;
                        endcase
                    end else if (errCount_q != 16'hFFFF) begin
                        errCount_d = errCount_q + 16'd1;
                    end
                end else if (sclkRise) begin
                    rx_d  = {rx_q[14:0], copiSync};
                    tx0_d = {tx0_q[30:0], 1'b0};
                    tx1_d = {tx1_q[30:0], 1'b0};
                    if (bitCnt_q != 5'd31) begin
                        bitCnt_d = bitCnt_q + 5'd1;
                    end
                end else if (sclkFall) begin
                    tx0_d = {tx0_q[30:0], 1'b0};
                    tx1_d = {tx1_q[30:0], 1'b0};
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            tx0_q        <= '0;
            tx1_q        <= '0;
            rx_q         <= '0;
            bitCnt_q     <= '0;
            frameCount_q <= '0;
            errCount_q   <= '0;
            lastCmd_q    <= '0;
            slotOld_q    <= '0;
            slotNew_q    <= '0;
            samp_q       <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            tx0_q        <= tx0_d;
            tx1_q        <= tx1_d;
            rx_q         <= rx_d;
            bitCnt_q     <= bitCnt_d;
            frameCount_q <= frameCount_d;
            errCount_q   <= errCount_d;
            lastCmd_q    <= lastCmd_d;
            slotOld_q    <= slotOld_d;
            slotNew_q    <= slotNew_d;
            samp_q       <= samp_d;
            regs_q       <= regs_d;
        end
    end

    logic cipoRaw0, cipoRaw1;

    assign cipoRaw0 = (state_q == ST_SHIFT) & tx0_q[31];
    assign cipoRaw1 = (state_q == ST_SHIFT) & tx1_q[31];

    assign frame_count     = frameCount_q;
    assign frame_err_count = errCount_q;
    assign last_cmd        = lastCmd_q;

`ifdef INTAN_EMU_CABLE_DELAY_EN
    logic [14:0] dly0_q, dly1_q;
    logic [15:0] tap0, tap1;

    assign tap0 = {dly0_q, cipoRaw0};
    assign tap1 = {dly1_q, cipoRaw1};

    // Cable delay line: tap k is the raw CIPO delayed by k clk cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            dly0_q <= '0;
            dly1_q <= '0;
        end else begin
            dly0_q <= tap0[14:0];
            dly1_q <= tap1[14:0];
        end
    end

    assign cipo0 = tap0[cable_delay];
    assign cipo1 = tap1[cable_delay];
`else
    logic unusedCableDelay;

    assign unusedCableDelay = ^cable_delay;
    assign cipo0            = cipoRaw0;
    assign cipo1            = cipoRaw1;
`endif

endmodule
